// File: rtl/data_mem_resp_pkg.sv
// data_mem_resp_pkg: FSM state encoding, default sizes and word width shared by data_mem_resp
package data_mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int LATENCY_DEF = 2;
  localparam int DEPTH_WORDS_DEF = 64;
  localparam int WORD_W = 32;
endpackage

// File: rtl/data_mem_resp_dmem_array.sv
// dmem_array: word array with synchronous write, combinational read and synchronous clear
// Ports: clock; reset (sync, active-low, clears every word); we/idx/wdata write port; rdata reads word idx
module dmem_array
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);
  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clock)
    if (!reset) mem <= '{default: '0};
    else if (we) mem[idx] <= wdata;
  assign rdata = mem[idx];
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-outstanding word memory responder with fixed request-to-response latency
// Ports: clock; reset (sync, active-low); req/we/addr/wdata request side, accepted while ready;
//        valid one-cycle response strobe with rdata (read data, held between reads) and err.
// Option: define DMEM_ALIGN_CHECK_EN to flag addr[1:0]!=0 with err and suppress the access.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int LATENCY     = LATENCY_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [7:0]        addr,
  input  logic [WORD_W-1:0] wdata,
  output logic              ready,
  output logic              valid,
  output logic [WORD_W-1:0] rdata,
  output logic              err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic we_q, mis, accept, rd_resp, commit;
  logic [IW-1:0] idx_q;
  logic [WORD_W-1:0] wdata_q, rdata_q, mem_rdata;
  assign accept  = state == IDLE && req;
  assign valid   = state == RESP;
  assign ready   = state == IDLE;
  assign rd_resp = valid && !we_q && !mis;
  assign commit  = valid && we_q && !mis;
  assign rdata   = rd_resp ? mem_rdata : rdata_q;
  assign err     = valid & mis;
  // The counter hits 0 on the WAIT->RESP transition, so WAIT lasts LATENCY-1 cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (accept) begin
      state_n = LATENCY == 1 ? RESP : WAIT;
      cnt_n   = LOAD;
    end else if (state == WAIT) begin
      cnt_n   = cnt - 4'd1;
      state_n = cnt == 4'd1 ? RESP : WAIT;
    end else if (state == RESP) state_n = IDLE;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        we_q    <= we;
        idx_q   <= addr[IW+1:2];
        wdata_q <= wdata;
      end
      if (rd_resp) rdata_q <= mem_rdata;
    end
`ifdef DMEM_ALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clock)
    if (!reset) mis_q <= 1'b0;
    else if (accept) mis_q <= addr[1:0] != 2'b00;
  assign mis = mis_q;
`else
  logic unused_addr;
  assign unused_addr = ^addr[1:0];
  assign mis = 1'b0;
`endif
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clock(clock),
    .reset(reset),
    .we(commit),
    .idx(idx_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed bench for data_mem_resp with a cycle-level reference model (LATENCY 2 and 1)
module tb_data_mem_resp;
  logic clk;
  logic [1:0] rst_n, req, we, ready, valid, err;
  logic [1:0][7:0] addr;
  logic [1:0][31:0] wdata, rdata;
  int total = 0, bad = 0;

  data_mem_resp #(.LATENCY(2)) u0 (
    .clock(clk), .reset(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ready(ready[0]), .valid(valid[0]), .rdata(rdata[0]), .err(err[0]));
  data_mem_resp #(.LATENCY(1)) u1 (
    .clock(clk), .reset(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ready(ready[1]), .valid(valid[1]), .rdata(rdata[1]), .err(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int i);
    return i == 0 ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction accepted in cycle N responds when N+lat cycles have elapsed.
  bit started [2];
  bit infl [2];
  int t [2];
  bit twe [2], tmis [2];
  int tidx [2];
  logic [31:0] twd [2], mrd [2];
  logic [31:0] mm [2][64];

  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        started[i] = 1;
        infl[i] = 0;
        mrd[i] = 0;
        for (int k = 0; k < 64; k++) mm[i][k] = 0;
      end else if (started[i]) begin
        bit v, rdy;
        v = infl[i] && t[i] == lat(i);
        rdy = !infl[i];
        if (v) begin
          if (twe[i]) begin
            if (!tmis[i]) mm[i][tidx[i]] = twd[i];
          end else if (!tmis[i]) mrd[i] = mm[i][tidx[i]];
          infl[i] = 0;
        end else if (infl[i]) t[i]++;
        if (rdy && req[i]) begin
          infl[i] = 1;
          t[i] = 1;
          twe[i] = we[i];
          tidx[i] = int'(addr[i][7:2]);
          twd[i] = wdata[i];
`ifdef DMEM_ALIGN_CHECK_EN
          tmis[i] = addr[i][1:0] != 2'b00;
`else
          tmis[i] = 0;
`endif
        end
      end
    end

  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (started[i]) begin
        logic v;
        logic [31:0] er;
        v = infl[i] && t[i] == lat(i);
        er = (v && !twe[i] && !tmis[i]) ? mm[i][tidx[i]] : mrd[i];
        chk($sformatf("model_ready%0d", i), ready[i], !infl[i]);
        chk($sformatf("model_valid%0d", i), valid[i], v);
        chk($sformatf("model_err%0d", i), err[i], v && tmis[i]);
        chk($sformatf("model_rdata%0d", i), rdata[i], er);
      end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int i, input bit w, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e);
    int n;
    req[i] = 1; we[i] = w; addr[i] = a; wdata[i] = d;
    tick();
    req[i] = 0;
    n = 1;
    while (!valid[i] && n < 20) begin
      tick();
      n++;
    end
    chk($sformatf("latency%0d", i), n, lat(i));
    rd = rdata[i];
    e = err[i];
    tick();
    chk($sformatf("ready_after%0d", i), ready[i], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic e;
    int acc, nv;
    logic [6:0] pat;
    rst_n = '0; req = '0; we = '0; addr = '0; wdata = '0;
    tick();
    tick();
    rst_n = '1;
    chk("rst_ready", ready[0], 1);
    chk("rst_valid", valid[0], 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_err", err[0], 0);
    // write then read-after-write
    xfer(0, 1, 8'h08, 32'hDEADBEEF, rd, e);
    chk("wr08_err", e, 0);
    xfer(0, 0, 8'h08, 0, rd, e);
    chk("rd08_data", rd, 32'hDEADBEEF);
    chk("rd08_err", e, 0);
    // write response leaves rdata alone
    xfer(0, 1, 8'h0C, 32'h11111111, rd, e);
    chk("wr0c_hold", rd, 32'hDEADBEEF);
    xfer(0, 0, 8'h10, 0, rd, e);
    chk("rd10_data", rd, 32'h0);
    // req held for 10 cycles starting in the RESP cycle of a read
    req[0] = 1; we[0] = 0; addr[0] = 8'h08;
    tick();
    req[0] = 0;
    tick();
    req[0] = 1;
    acc = 0; nv = 0; pat = '0;
    for (int k = 0; k < 13; k++) begin
      if (k == 10) req[0] = 0;
      if (k >= 1 && k <= 7) pat[7-k] = ready[0];
      if (ready[0] && req[0]) acc++;
      if (valid[0] && k >= 1) nv++;
      tick();
    end
    chk("hold_accepts", acc, 3);
    chk("hold_valids", nv, 3);
    chk("hold_ready_pat", pat, 7'b1001001);
    // reset mid-operation discards the write
    req[0] = 1; we[0] = 1; addr[0] = 8'h04; wdata[0] = 32'h12345678;
    tick();
    req[0] = 0;
    rst_n[0] = 0;
    tick();
    chk("midrst_valid", valid[0], 0);
    rst_n[0] = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_novalid", valid[0], 0);
    end
    xfer(0, 0, 8'h04, 0, rd, e);
    chk("midrst_rd04", rd, 32'h0);
    chk("midrst_rd08", valid[0], 0);
`ifdef DMEM_ALIGN_CHECK_EN
    xfer(0, 1, 8'h05, 32'hFFFFFFFF, rd, e);
    chk("mis_err", e, 1);
    xfer(0, 0, 8'h04, 0, rd, e);
    chk("mis_rd04", rd, 32'h0);
    chk("mis_rd_err", e, 0);
`endif
    // LATENCY=1 back-to-back reads
    xfer(1, 1, 8'h00, 32'h0BADF00D, rd, e);
    xfer(1, 1, 8'hFC, 32'hCAFEF00D, rd, e);
    req[1] = 1; we[1] = 0; addr[1] = 8'h00;
    tick();
    chk("l1_v1", valid[1], 1);
    chk("l1_r1", ready[1], 0);
    chk("l1_d1", rdata[1], 32'h0BADF00D);
    addr[1] = 8'hFC;
    tick();
    chk("l1_v2", valid[1], 0);
    chk("l1_r2", ready[1], 1);
    tick();
    req[1] = 0;
    chk("l1_v3", valid[1], 1);
    chk("l1_r3", ready[1], 0);
    chk("l1_d3", rdata[1], 32'hCAFEF00D);
    tick();
    chk("l1_v4", valid[1], 0);
    chk("l1_r4", ready[1], 1);
    chk("l1_hold", rdata[1], 32'hCAFEF00D);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from request accept to response (legal range 1..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words stored (byte address space 4*DEPTH_WORDS = 256).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req  input  1  the initiator requests a transfer.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  8  byte address; word index = addr[7:2].
REQ-008 SHALL have port wdata  input  32  write data; sampled with req.
REQ-009 SHALL have port ready  output  1  the responder can accept a request this cycle.
REQ-010 SHALL have port valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rdata  output  32  read data, meaningful when valid is high after a read.
REQ-012 SHALL have port err  output  1  the response carries an error; qualified by valid.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; ready=1 only in IDLE.
REQ-014 SHALL accept a request in any cycle N where req=1 and ready=1, capturing we, addr and wdata at that edge.
REQ-015 SHALL ignore req while ready=0: no capture, no queuing, no effect on the transaction in flight.
REQ-016 SHALL drive valid=1 in exactly cycle N+LATENCY and valid=0 in all other cycles; for LATENCY=1 the FSM SHALL go IDLE->RESP and skip WAIT.
REQ-017 SHALL use a 4-bit down-counter, loaded with LATENCY-1 on accept, to time WAIT; WAIT->RESP when the counter reaches 0.
REQ-018 SHALL return RESP->IDLE unconditionally, so ready=1 in cycle N+LATENCY+1; sustained throughput is one transfer per LATENCY+1 cycles.
REQ-019 SHALL commit a write to the word array at the clock edge ending cycle N+LATENCY, never earlier.
REQ-020 SHALL present on rdata during RESP the word stored at the captured index; rdata SHALL hold that value until the next read response.
REQ-021 SHALL leave rdata unchanged on a write response.
REQ-022 SHALL return the newly written value to a read accepted after a write response to the same word (read-after-write).
REQ-023 SHALL drive err=0 on every response when the error feature is compiled out.

Reset
REQ-024 SHALL, while reset=0 at a rising edge, force state IDLE, counter 0, ready=1 from the following cycle, valid=0, rdata=0, err=0, and all memory words to 0.
REQ-025 SHALL discard an in-flight transaction when reset is asserted mid-operation: no write commits and no valid is issued.

Configuration
REQ-026 SHALL honour macro DMEM_ALIGN_CHECK_EN: when defined, a request with addr[1:0]!=0 completes with normal timing, err=1 in RESP, no write commit, and rdata unchanged.
REQ-027 SHALL, without DMEM_ALIGN_CHECK_EN, ignore addr[1:0], leave err tied to 0, and contain no alignment logic.

Structure
REQ-028 SHALL place in the shared package the FSM state enumeration (2-bit encoding), the default constants for LATENCY and DEPTH_WORDS, and the word width (32).
REQ-029 SHALL contain exactly one sub-module, dmem_array (synchronous-write, combinational-read word array with reset clear); FSM and counter SHALL remain in data_mem_resp.

Verification
REQ-030 SHALL cover: reset, then write addr=0x08 wdata=0xDEADBEEF (LATENCY=2) -> valid in cycle N+2, err=0; then read 0x08 -> rdata=0xDEADBEEF.
REQ-031 SHALL cover: read addr=0x10 after reset -> rdata=0x00000000 with valid exactly 2 cycles after accept.
REQ-032 SHALL cover: req held high for 10 cycles, LATENCY=2 -> exactly 3 accepts, ready pattern 1,0,0,1,0,0,1, one valid per accept.
REQ-033 SHALL cover: write 0x04 <- 0x12345678, reset=0 asserted in cycle N+1 -> no valid; read 0x04 after reset -> 0x00000000.
REQ-034 SHALL cover, with DMEM_ALIGN_CHECK_EN: write addr=0x05 wdata=0xFFFFFFFF -> valid with err=1; read 0x04 -> 0x00000000, err=0.
REQ-035 SHALL cover: LATENCY=1, back-to-back read 0x00, read 0xFC -> valid in cycles N+1 and N+3; ready 0 only in cycles N+1 and N+3.
